// File: rtl/prism_sp_unit_rx.sv
// prism_sp_unit_rx: receive-side command unit of the PRISM stream processor.
// Executes one-hot custom instructions: metadata pop / empty query, RX data
// FIFO fill (bytes), and DMA start / status for draining the RX data FIFO.
// Build option: define PRISM_SP_UNIT_RX_DMA_EN to include the DMA control
// path; without it the rx_dma_* outputs are tied 0 and the DMA commands
// complete in one cycle with result 0.
module prism_sp_unit_rx #(
   parameter int RESULT_WIDTH = 32,
   parameter int COUNT_WIDTH  = 12,
   parameter int DATA_BYTES   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic [4:0]              issue_cmd,
   input  logic [RESULT_WIDTH-1:0] rs1,
   input  logic [RESULT_WIDTH-1:0] rs2,
   output logic                    cmd_done,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    rx_meta_rd_en,
   input  logic [RESULT_WIDTH-1:0] rx_meta_rd_data,
   input  logic                    rx_meta_empty,
   input  logic [COUNT_WIDTH-1:0]  rx_data_count,
   output logic                    rx_dma_start,
   output logic [RESULT_WIDTH-1:0] rx_dma_addr,
   output logic [15:0]             rx_dma_len,
   output logic                    rx_dma_last,
   input  logic                    rx_dma_busy
);

   localparam int BYTE_SHIFT = $clog2(DATA_BYTES);

   // One-hot command bit positions.
   localparam int CMD_META_POP   = 0;
   localparam int CMD_META_EMPTY = 1;
   localparam int CMD_DATA_COUNT = 2;
   localparam int CMD_DMA_START  = 3;
   localparam int CMD_DMA_STATUS = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT,
      S_POP,
      S_CAPT
   } state_e;

   state_e                  state_q, state_d;
   logic [4:0]              cmd_q, cmd_d;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic [RESULT_WIDTH-1:0] result_now;
   logic                    done;
   logic                    meta_rd;
   logic                    dma_go;

`ifdef PRISM_SP_UNIT_RX_DMA_EN
   logic [RESULT_WIDTH-1:0] rs1_q, rs1_d;
   logic [RESULT_WIDTH-1:0] rs2_q, rs2_d;
   logic [RESULT_WIDTH-1:0] dma_addr_q, dma_addr_d;
   logic [15:0]             dma_len_q, dma_len_d;
   logic                    dma_last_q, dma_last_d;
   logic                    unused_rs2_mid;

   // Only len and the last flag are taken from rs2.
   assign unused_rs2_mid = ^rs2_q[RESULT_WIDTH-2:16];
`else
   logic unused_dma_inputs;

   // Operands and DMA busy have no consumer when the DMA path is removed.
   assign unused_dma_inputs = ^{rs1, rs2, rx_dma_busy};
`endif

   // Next-state, completion and result selection for the command FSM.
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
      state_d    = state_q;
      cmd_d      = cmd_q;
      result_d   = result_q;
      result_now = result_q;
      done       = 1'b0;
      meta_rd    = 1'b0;
      dma_go     = 1'b0;
`ifdef PRISM_SP_UNIT_RX_DMA_EN
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (issue_valid) begin
               cmd_d   = issue_cmd;
`ifdef PRISM_SP_UNIT_RX_DMA_EN
               rs1_d   = rs1;
               rs2_d   = rs2;
`endif
               state_d = (issue_cmd == 5'b00001) ? S_WAIT : S_EXEC;
            end
         end
         S_EXEC: begin
            done    = 1'b1;
            state_d = S_IDLE;
            if (!$onehot(cmd_q)) begin
               result_now = '1;
            end else if (cmd_q[CMD_META_EMPTY]) begin
               result_now = RESULT_WIDTH'(rx_meta_empty);
            end else if (cmd_q[CMD_DATA_COUNT]) begin
               result_now = RESULT_WIDTH'(rx_data_count) << BYTE_SHIFT;
`ifdef PRISM_SP_UNIT_RX_DMA_EN
            end else if (cmd_q[CMD_DMA_STATUS]) begin
               result_now = RESULT_WIDTH'(rx_dma_busy);
            end else if (cmd_q[CMD_DMA_START]) begin
               result_now = '0;
               // Hold off until the previous transfer has drained.
               if (rx_dma_busy) begin
                  done    = 1'b0;
                  state_d = S_EXEC;
               end else begin
                  dma_go  = 1'b1;
               end
`endif
            end else begin
               result_now = '0;
            end
         end
         S_WAIT: begin
            if (!rx_meta_empty) state_d = S_POP;
         end
         S_POP: begin
            meta_rd = 1'b1;
            state_d = S_CAPT;
         end
         S_CAPT: begin
            done       = 1'b1;
            result_now = rx_meta_rd_data;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (done) result_d = result_now;
   end

`ifdef PRISM_SP_UNIT_RX_DMA_EN
   // DMA descriptor registers change only on a start, so they hold between starts.
   always_comb begin
      dma_addr_d = dma_addr_q;
      dma_len_d  = dma_len_q;
      dma_last_d = dma_last_q;
      if (dma_go) begin
         dma_addr_d = rs1_q;
         dma_len_d  = rs2_q[15:0];
         dma_last_d = rs2_q[RESULT_WIDTH-1];
      end
   end
`endif

   // State and datapath registers; async reset abandons any in-flight command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         result_q   <= '0;
`ifdef PRISM_SP_UNIT_RX_DMA_EN
         rs1_q      <= '0;
         rs2_q      <= '0;
         dma_addr_q <= '0;
         dma_len_q  <= '0;
         dma_last_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         result_q   <= result_d;
`ifdef PRISM_SP_UNIT_RX_DMA_EN
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         dma_addr_q <= dma_addr_d;
         dma_len_q  <= dma_len_d;
         dma_last_q <= dma_last_d;
`endif
      end
   end

   assign issue_ready   = (state_q == S_IDLE);
   assign cmd_done      = done;
   assign result        = result_now;
   assign rx_meta_rd_en = meta_rd;

`ifdef PRISM_SP_UNIT_RX_DMA_EN
   assign rx_dma_start = dma_go;
   assign rx_dma_addr  = dma_addr_d;
   assign rx_dma_len   = dma_len_d;
   assign rx_dma_last  = dma_last_d;
`else
   assign rx_dma_start = 1'b0;
   assign rx_dma_addr  = '0;
   assign rx_dma_len   = '0;
   assign rx_dma_last  = 1'b0;
`endif

endmodule

// File: tb/tb_prism_sp_unit_rx.sv
// Directed bench for prism_sp_unit_rx; expected results queued at issue and
// compared when cmd_done is seen. Inputs change 1 ns after posedge, outputs
// are sampled at negedge.
module tb_prism_sp_unit_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_cmd;
   logic [31:0] rs1, rs2;
   logic        cmd_done;
   logic [31:0] result;
   logic        rx_meta_rd_en;
   logic [31:0] rx_meta_rd_data;
   logic        rx_meta_empty;
   logic [11:0] rx_data_count;
   logic        rx_dma_start;
   logic [31:0] rx_dma_addr;
   logic [15:0] rx_dma_len;
   logic        rx_dma_last;
   logic        rx_dma_busy;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_q[$];
   logic [31:0] meta_word = 32'h0;

   int rd_cnt = 0, rd_empty_cnt = 0, start_cnt = 0, done_cnt = 0;

   localparam logic [4:0] C_POP    = 5'b00001;
   localparam logic [4:0] C_EMPTY  = 5'b00010;
   localparam logic [4:0] C_COUNT  = 5'b00100;
   localparam logic [4:0] C_DSTART = 5'b01000;
   localparam logic [4:0] C_DSTAT  = 5'b10000;

   prism_sp_unit_rx #(
      .RESULT_WIDTH(32),
      .COUNT_WIDTH (12),
      .DATA_BYTES  (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_cmd      (issue_cmd),
      .rs1            (rs1),
      .rs2            (rs2),
      .cmd_done       (cmd_done),
      .result         (result),
      .rx_meta_rd_en  (rx_meta_rd_en),
      .rx_meta_rd_data(rx_meta_rd_data),
      .rx_meta_empty  (rx_meta_empty),
      .rx_data_count  (rx_data_count),
      .rx_dma_start   (rx_dma_start),
      .rx_dma_addr    (rx_dma_addr),
      .rx_dma_len     (rx_dma_len),
      .rx_dma_last    (rx_dma_last),
      .rx_dma_busy    (rx_dma_busy)
   );

   always #5 clk = ~clk;

   // Metadata FIFO read port: data valid the cycle after rd_en, junk otherwise.
   always @(posedge clk) begin
      rx_meta_rd_data <= rx_meta_rd_en ? meta_word : 32'h0BAD_0BAD;
   end

   // Side-effect monitor.
   always @(posedge clk) begin
      if (rx_meta_rd_en) rd_cnt++;
      if (rx_meta_rd_en && rx_meta_empty) rd_empty_cnt++;
      if (rx_dma_start) start_cnt++;
      if (cmd_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one command for one cycle; the expected result goes on the scoreboard.
   task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
      exp_q.push_back(exp_res);
      issue_valid = 1'b1;
      issue_cmd   = c;
      rs1         = a;
      rs2         = b;
      @(negedge clk);
      check("ready_at_issue", issue_ready, 1);
      step();
      issue_valid = 1'b0;
      issue_cmd   = 5'b0;
   endtask

   // Wait for cmd_done (bounded), check latency, result and start coincidence.
   task automatic await_done(input string tag, input int first_lat, input int exp_lat,
                             input logic exp_start);
      int          lat  = first_lat;
      bit          seen = 0;
      logic [31:0] exp_res;
      for (int i = 0; i < 32 && !seen; i++) begin
         @(negedge clk);
         if (cmd_done) begin
            seen    = 1;
            exp_res = exp_q.pop_front();
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_result"}, result, exp_res);
            check({tag, "_dma_start"}, rx_dma_start, exp_start);
            check({tag, "_ready_low"}, issue_ready, 0);
         end else begin
            lat++;
         end
         step();
      end
      if (!seen) begin
         check({tag, "_timeout"}, 0, 1);
         exp_q.delete();
      end
   endtask

   initial begin
      int rd0, st0, dn0;

      rst_n         = 1'b0;
      issue_valid   = 1'b0;
      issue_cmd     = 5'b0;
      rs1           = '0;
      rs2           = '0;
      rx_meta_empty = 1'b1;
      rx_data_count = '0;
      rx_dma_busy   = 1'b0;

      step();
      step();
      @(negedge clk);
      check("reset_outputs",
            {cmd_done, result, rx_meta_rd_en, rx_dma_start, rx_dma_addr, rx_dma_len, rx_dma_last},
            '0);
      check("reset_ready", issue_ready, 1);
      rst_n = 1'b1;
      step();

      // Data FIFO fill in bytes.
      rx_data_count = 12'd5;
      issue(C_COUNT, 0, 0, 32'd40);
      await_done("count5", 1, 1, 0);
      rx_data_count = 12'hFFF;
      issue(C_COUNT, 0, 0, 32'h7FF8);
      await_done("count_max", 1, 1, 0);

      // Metadata empty query, both polarities.
      rx_meta_empty = 1'b1;
      issue(C_EMPTY, 0, 0, 32'd1);
      await_done("empty1", 1, 1, 0);
      rx_meta_empty = 1'b0;
      issue(C_EMPTY, 0, 0, 32'd0);
      await_done("empty0", 1, 1, 0);

      // Blocking pop: FIFO empty for 4 cycles, valid requests meanwhile ignored.
      rd0           = rd_cnt;
      dn0           = done_cnt;
      rx_meta_empty = 1'b1;
      meta_word     = 32'hDEAD_BEEF;
      issue(C_POP, 0, 0, 32'hDEAD_BEEF);
      issue_valid   = 1'b1;
      issue_cmd     = C_COUNT;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("pop_wait_idle", {cmd_done, rx_meta_rd_en, issue_ready}, 3'b000);
         step();
      end
      issue_valid   = 1'b0;
      issue_cmd     = 5'b0;
      rx_meta_empty = 1'b0;
      await_done("pop", 5, 7, 0);
      check("pop_rd_count", rd_cnt - rd0, 1);
      check("pop_done_count", done_cnt - dn0, 1);
      check("pop_rd_while_empty", rd_empty_cnt, 0);

      // Minimum-latency pop with FIFO already non-empty.
      meta_word = 32'h1234_5678;
      issue(C_POP, 0, 0, 32'h1234_5678);
      await_done("pop_fast", 1, 3, 0);

      // Illegal commands: all-ones, no side effects.
      rd0 = rd_cnt;
      st0 = start_cnt;
      issue(5'b00011, 0, 0, 32'hFFFF_FFFF);
      await_done("illegal_multi", 1, 1, 0);
      issue(5'b00000, 0, 0, 32'hFFFF_FFFF);
      await_done("illegal_zero", 1, 1, 0);
      check("illegal_side_effects", {rd_cnt - rd0, start_cnt - st0}, 0);

`ifdef PRISM_SP_UNIT_RX_DMA_EN
      // DMA start with idle engine, then status while busy.
      st0         = start_cnt;
      rx_dma_busy = 1'b0;
      issue(C_DSTART, 32'h1000, 32'h8000_0040, 32'h0);
      await_done("dma_start", 1, 1, 1);
      check("dma_desc", {rx_dma_addr, rx_dma_len, rx_dma_last}, {32'h1000, 16'h0040, 1'b1});
      check("dma_start_count", start_cnt - st0, 1);
      rx_dma_busy = 1'b1;
      issue(C_DSTAT, 0, 0, 32'd1);
      await_done("dma_status", 1, 1, 0);

      // DMA start while busy for 3 cycles (accept cycle plus two).
      st0 = start_cnt;
      issue(C_DSTART, 32'h2000, 32'h0000_0010, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("dma_busy_hold", {cmd_done, rx_dma_start}, 2'b00);
         check("dma_desc_held", {rx_dma_addr, rx_dma_len, rx_dma_last}, {32'h1000, 16'h0040, 1'b1});
         step();
      end
      rx_dma_busy = 1'b0;
      await_done("dma_start_busy", 3, 3, 1);
      check("dma_desc2", {rx_dma_addr, rx_dma_len, rx_dma_last}, {32'h2000, 16'h0010, 1'b0});
      check("dma_start_count2", start_cnt - st0, 1);
`else
      // DMA path removed: commands complete with 0 and never start anything.
      st0         = start_cnt;
      rx_dma_busy = 1'b1;
      issue(C_DSTART, 32'h1000, 32'h8000_0040, 32'h0);
      await_done("nodma_start", 1, 1, 0);
      issue(C_DSTAT, 0, 0, 32'h0);
      await_done("nodma_status", 1, 1, 0);
      check("nodma_outputs", {rx_dma_addr, rx_dma_len, rx_dma_last, start_cnt - st0}, '0);
      rx_dma_busy = 1'b0;
`endif

      // Reset during pop wait: command abandoned, no read, no done.
      rd0           = rd_cnt;
      dn0           = done_cnt;
      rx_meta_empty = 1'b1;
      issue(C_POP, 0, 0, 32'h0);
      exp_q.delete();
      step();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", {cmd_done, rx_meta_rd_en, issue_ready}, 3'b001);
      step();
      rst_n         = 1'b1;
      rx_meta_empty = 1'b0;
      for (int i = 0; i < 3; i++) step();
      @(negedge clk);
      check("rst_mid_ready", issue_ready, 1);
      check("rst_mid_no_rd", rd_cnt - rd0, 0);
      check("rst_mid_no_done", done_cnt - dn0, 0);
      check("rst_mid_result", result, 0);
      step();

      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
